// File: rtl/snake_body_tracker.sv
// Snake segment list (head = seg[0]) with stepping, growth, collision and cell query.
// Build macro SNAKE_WRAP_EN: the head wraps across the border instead of colliding with it.
module snake_seg_match (
    input  logic       i_active,
    input  logic [3:0] i_sx,
    input  logic [3:0] i_sy,
    input  logic [3:0] i_qx,
    input  logic [3:0] i_qy,
    output logic       o_hit
);
    assign o_hit = i_active && (i_sx == i_qx) && (i_sy == i_qy);
endmodule

module snake_body_tracker #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 4,
    parameter int START_Y  = 7,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          step,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    input  logic          grow,
    input  logic [3:0]    x,
    input  logic [3:0]    y,
    output logic          snakeHead,
    output logic          snakeBody,
    output logic [3:0]    head_x,
    output logic [3:0]    head_y,
    output logic [LW-1:0] length,
    output logic          collide
);
    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_L = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;

    logic [MAX_LEN-1:0][3:0] r_seg_x, r_seg_y;
    logic [LW-1:0]           r_len;
    logic [1:0]              r_dir, r_last_dir;
    logic                    r_grow_pend, r_collide;

    logic       w_dir_ok, w_growing, w_wall, w_self;
    logic [1:0] w_dir_eff;
    logic [3:0] w_nx, w_ny;
    logic [MAX_LEN-1:0] w_hit;

    // Reversal is judged against the direction actually moved last, not the pending one.
    assign w_dir_ok  = dir_valid && (dir != {r_last_dir[1], ~r_last_dir[0]});
    assign w_dir_eff = w_dir_ok ? dir : r_dir;
    assign w_growing = grow | r_grow_pend;

    always_comb begin
        w_nx = r_seg_x[0];
        w_ny = r_seg_y[0];
        case (w_dir_eff)
            DIR_R:   w_nx = r_seg_x[0] + 4'd1;
            DIR_L:   w_nx = r_seg_x[0] - 4'd1;
            DIR_U:   w_ny = r_seg_y[0] - 4'd1;
            default: w_ny = r_seg_y[0] + 4'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        w_wall = 1'b0;
        if (w_nx == 4'd0) w_nx = 4'd14;
        else if (w_nx == 4'd15) w_nx = 4'd1;
        if (w_ny == 4'd0) w_ny = 4'd14;
        else if (w_ny == 4'd15) w_ny = 4'd1;
`else
        w_wall = (w_nx == 4'd0) || (w_nx == 4'd15) || (w_ny == 4'd0) || (w_ny == 4'd15);
`endif
    end

    // The tail cell is free to enter unless it stays put because the snake grows.
    always_comb begin
        w_self = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < r_len) && (w_growing || (LW'(i) != r_len - LW'(1))) &&
                (w_nx == r_seg_x[i]) && (w_ny == r_seg_y[i]))
                w_self = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 4'(START_X - i) : 4'd0;
                r_seg_y[i] <= (i < INIT_LEN) ? 4'(START_Y) : 4'd0;
            end
            r_len       <= LW'(INIT_LEN);
            r_dir       <= DIR_R;
            r_last_dir  <= DIR_R;
            r_grow_pend <= 1'b0;
            r_collide   <= 1'b0;
        end else begin
            if (w_dir_ok) r_dir <= dir;
            if (grow) r_grow_pend <= 1'b1;
            if (step && !r_collide) begin
                if (w_wall || w_self) begin
                    r_collide <= 1'b1;
                end else begin
                    r_seg_x     <= {r_seg_x[MAX_LEN-2:0], w_nx};
                    r_seg_y     <= {r_seg_y[MAX_LEN-2:0], w_ny};
                    r_last_dir  <= w_dir_eff;
                    r_grow_pend <= 1'b0;
                    if (w_growing && (r_len < LW'(MAX_LEN))) r_len <= r_len + LW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_match
        snake_seg_match u_match (
            .i_active ((g == 0) ? 1'b1 : (LW'(g) < r_len)),
            .i_sx     (r_seg_x[g]),
            .i_sy     (r_seg_y[g]),
            .i_qx     (x),
            .i_qy     (y),
            .o_hit    (w_hit[g])
        );
    end

    assign snakeHead = w_hit[0];
    assign snakeBody = |w_hit[MAX_LEN-1:1];
    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign length    = r_len;
    assign collide   = r_collide;
endmodule

// File: doc/snake_body_tracker.md
Name: snake_body_tracker

Overview:
- Holds the snake as an ordered list of grid segments: head first, tail last.
- Advances the snake one cell per game tick, grows it when an apple is eaten, and flags wall and self collisions.
- Sits directly upstream of image_generator. It answers that block's (x, y) cell query with snakeHead/snakeBody, and its collision flag feeds GameOver.

Parameters:
- MAX_LEN, 16, maximum segment count; legal range 4..32.
- INIT_LEN, 3, segment count after reset; must be ≤ MAX_LEN.
- START_X, 4, head x after reset.
- START_Y, 7, head y after reset.

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- step  input  1  one-cycle pulse; advance the snake one cell.
- dir_valid  input  1  qualifies dir.
- dir  input  2  requested direction: 00 right (+x), 01 left (-x), 10 up (-y), 11 down (+y).
- grow  input  1  one-cycle pulse; an apple was eaten.
- x  input  4  query column, from image_generator.
- y  input  4  query row, from image_generator.
- snakeHead  output  1  query cell holds the head.
- snakeBody  output  1  query cell holds a non-head active segment.
- head_x  output  4  current head column.
- head_y  output  4  current head row.
- length  output  $clog2(MAX_LEN+1)  active segment count.
- collide  output  1  sticky collision flag.

Behaviour:
- Reset (asynchronous, nrst low):
  - seg[i] = (START_X-i, START_Y) for i < INIT_LEN; all other seg[i] = (0,0).
  - length = INIT_LEN; dir_reg = right; grow_pend = 0; collide = 0.
- Playfield:
  - x and y range 0..15.
  - Cells with x or y equal to 0 or 15 are border; legal head cells are 1..14 on both axes.
- Direction register:
  - On dir_valid, dir is loaded into dir_reg unless it is the 180° reverse of the direction used at the last step; a reverse request is dropped.
  - Before the first step, the reverse check uses the reset direction (right).
  - dir_valid in the same cycle as step takes effect for that step.
- grow handling:
  - grow sets grow_pend.
  - grow in the same cycle as step applies to that step.
- Step, when step=1 and collide=0:
  - nh = seg[0] moved one cell in the effective direction, using 4-bit arithmetic.
  - If nh is a border cell: collide←1; segments, length and grow_pend are unchanged.
  - Otherwise check self-collision: nh equals seg[i] for any 1 ≤ i < length. When not growing, seg[length-1] is excluded because the tail vacates it.
  - On a self-hit: collide←1; segments unchanged.
  - Otherwise: seg[i]←seg[i-1] for i ≥ 1, seg[0]←nh.
  - If growing and length < MAX_LEN: length←length+1, keeping the old tail as the new last segment.
  - grow_pend←0 in all non-colliding cases, including when the grow is ignored at saturation.
- Latency: all updates are visible on outputs one cycle after the step edge.
- collide=1: step is ignored. collide clears only on reset.
- Query path:
  - Purely combinational from registers, zero latency.
  - snakeHead = (x,y)==seg[0].
  - snakeBody = OR over 1 ≤ i < length of (x,y)==seg[i].
  - Segments at index ≥ length never match.
- head_x/head_y mirror seg[0]. Segment storage is an array of registers, not memory.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined:
  - Moving into column 0 wraps the head to 14; column 15 wraps to 1. Rows behave the same.
  - No wall collision occurs; only self collision sets collide.
- Undefined: border entry sets collide as described in Behaviour.

Test Plan:
- Reset defaults: release nrst → head (4,7), length 3. Query (3,7) → snakeBody=1. Query (4,7) → snakeHead=1, snakeBody=0. Query (1,7) → both 0.
- Turn and move: dir_valid with dir=11, then step → head (4,8), body at (4,7),(3,7). (2,7) no longer matches. length=3.
- Reverse rejected: moving right, issue dir=01 then step → head (5,7), not (3,7).
- Growth and saturation:
  - grow pulse, then step two cycles later → length 4, old tail retained.
  - Repeated grow+step to MAX_LEN=16 → length stays 16 on a further grow+step.
- Wall: from head (14,7) moving right, step:
  - without SNAKE_WRAP_EN → collide=1, head stays (14,7), later steps ignored.
  - with SNAKE_WRAP_EN → head (1,7), collide=0.
- Self collision and tail chase:
  - Length 5, steering the head into a mid-body cell → collide=1.
  - Length 4 in a 2x2 loop, stepping into the vacating tail cell without grow → no collision.
  - Same loop with grow → collide=1.
  - Assert nrst mid-game → all reset values restored.
